countdown_timer: RTL and testbench



---
 rtl/microwave_pkg.sv | 23 ++
 rtl/countdown_timer_if.sv | 27 ++
 rtl/bcd_down_digit.sv | 30 +++
 rtl/countdown_timer.sv | 110 +++++++++++
 tb/tb_countdown_timer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared constants and types for the microwave cook-time datapath.
// BCD digit width, digit reload limits and the timer action encoding.
package microwave_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   localparam bcd_t DIGIT_MAX    = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;

   // What the timer does on a given clock edge; load and count never coexist.
   typedef enum logic [1:0] {
      ACT_NONE  = 2'd0,
      ACT_LOAD  = 2'd1,
      ACT_COUNT = 2'd2
   } timer_act_e;

   function automatic logic is_bcd_digit(input bcd_t d);
      return (d <= DIGIT_MAX);
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keypad-side inputs and display-side outputs of the countdown timer.
// The timer takes the slave view; whoever drives the keypad takes the master view.
interface countdown_timer_if;
   import microwave_pkg::*;

   bcd_t D;
   logic loadn;
   logic pgt_1hz;
   logic enablen;

   bcd_t sec_ones;
   bcd_t sec_tens;
   bcd_t mins;
   logic zero;
   logic done;

   modport master (
      output D, loadn, pgt_1hz, enablen,
      input  sec_ones, sec_tens, mins, zero, done
   );

   modport slave (
      input  D, loadn, pgt_1hz, enablen,
      output sec_ones, sec_tens, mins, zero, done
   );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the cook time: parallel load, or step down with wrap to RELOAD
// when every lower digit is already zero (borrow_in).
module bcd_down_digit
   import microwave_pkg::*;
#(
   parameter bcd_t RELOAD = DIGIT_MAX
) (
   input  logic clk,
   input  logic clear,
   input  logic load,
   input  bcd_t load_val,
   input  logic dec,
   input  logic borrow_in,
   output bcd_t q,
   output logic is_zero
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (dec && borrow_in) begin
         q <= (q == '0) ? RELOAD : (q - bcd_t'(1));
      end
   end

   assign is_zero = (q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Microwave cook-time counter: keyed BCD digits shift in from the right in entry
// mode, and the m:ss value counts down once per 1 Hz tick while cooking.
module countdown_timer
   import microwave_pkg::*;
#(
   parameter bcd_t DIGIT_MAX    = microwave_pkg::DIGIT_MAX,
   parameter bcd_t SEC_TENS_MAX = microwave_pkg::SEC_TENS_MAX
) (
   input  logic              clk,
   input  logic              clear,
   countdown_timer_if.slave  tmr
);

   logic       loadn_q;
   logic       pgt_q;
   logic       load_ev;
   logic       tick_ev;
   timer_act_e act;
   logic       do_load;
   logic       do_dec;

   bcd_t       ones_q;
   bcd_t       tens_q;
   bcd_t       mins_q;
   logic       ones_zero;
   logic       tens_zero;
   logic       mins_zero;
   logic       zero;
   logic       done_q;

   // Edge detectors run in both modes so that flipping enablen cannot fake an event.
   always_ff @(posedge clk) begin
      if (clear) begin
         loadn_q <= 1'b1;
         pgt_q   <= 1'b0;
      end else begin
         loadn_q <= tmr.loadn;
         pgt_q   <= tmr.pgt_1hz;
      end
   end

   assign load_ev = !tmr.loadn && loadn_q;
   assign tick_ev = tmr.pgt_1hz && !pgt_q;

   always_comb begin
      act = ACT_NONE;
      if (tmr.enablen) begin
         if (load_ev && is_bcd_digit(tmr.D)) begin
            act = ACT_LOAD;
         end
      end else if (tick_ev && !zero) begin
         act = ACT_COUNT;
      end
   end

   assign do_load = (act == ACT_LOAD);
   assign do_dec  = (act == ACT_COUNT);

   // Loading shifts the display left: D -> ones -> tens -> mins, old mins dropped.
   bcd_down_digit #(.RELOAD(DIGIT_MAX)) u_ones (
      .clk       (clk),
      .clear     (clear),
      .load      (do_load),
      .load_val  (tmr.D),
      .dec       (do_dec),
      .borrow_in (1'b1),
      .q         (ones_q),
      .is_zero   (ones_zero)
   );

   bcd_down_digit #(.RELOAD(SEC_TENS_MAX)) u_tens (
      .clk       (clk),
      .clear     (clear),
      .load      (do_load),
      .load_val  (ones_q),
      .dec       (do_dec),
      .borrow_in (ones_zero),
      .q         (tens_q),
      .is_zero   (tens_zero)
   );

   bcd_down_digit #(.RELOAD(DIGIT_MAX)) u_mins (
      .clk       (clk),
      .clear     (clear),
      .load      (do_load),
      .load_val  (tens_q),
      .dec       (do_dec),
      .borrow_in (ones_zero && tens_zero),
      .q         (mins_q),
      .is_zero   (mins_zero)
   );

   assign zero = ones_zero && tens_zero && mins_zero;

   // A decrement lands on 0:00 only from 0:01.
   always_ff @(posedge clk) begin
      if (clear) begin
         done_q <= 1'b0;
      end else begin
         done_q <= do_dec && mins_zero && tens_zero && (ones_q == bcd_t'(1));
      end
   end

   assign tmr.sec_ones = ones_q;
   assign tmr.sec_tens = tens_q;
   assign tmr.mins     = mins_q;
   assign tmr.zero     = zero;
   assign tmr.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each scenario queues expected m:ss/zero/done
// snapshots alongside the sampled DUT state and drains the queue with inline compares.
module tb_countdown_timer;
   import microwave_pkg::*;

   typedef struct {
      string      name;
      logic [13:0] exp;
      logic [13:0] obs;
   } sb_t;

   logic clk = 1'b0;
   logic clear;
   int   total = 0;
   int   passed = 0;
   sb_t  sb_q[$];
   logic [13:0] tick_first;
   logic [13:0] tick_after;

   countdown_timer_if tif ();

   countdown_timer #(
      .DIGIT_MAX    (4'd9),
      .SEC_TENS_MAX (4'd5)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .tmr   (tif)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] snap();
      return {tif.mins, tif.sec_tens, tif.sec_ones, tif.zero, tif.done};
   endfunction

   // Expected zero is derived from the expected digits, not from the DUT.
   task automatic push(input string name, input logic [13:0] obs,
                       input bcd_t m, input bcd_t t, input bcd_t o, input logic d);
      sb_t e;
      e.name = name;
      e.exp  = {m, t, o, (m == 4'd0 && t == 4'd0 && o == 4'd0), d};
      e.obs  = obs;
      sb_q.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input bcd_t d);
      tif.D     = d;
      tif.loadn = 1'b0;
      cyc(10);
      tif.loadn = 1'b1;
      cyc(2);
   endtask

   task automatic tick();
      tif.pgt_1hz = 1'b1;
      cyc(1);
      tick_first = snap();
      cyc(1);
      tick_after = snap();
      cyc(2);
      tif.pgt_1hz = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset();
      sb_t e;
      clear       = 1'b1;
      tif.D       = 4'd0;
      tif.loadn   = 1'b1;
      tif.pgt_1hz = 1'b0;
      tif.enablen = 1'b1;
      cyc(3);
      push("reset", snap(), 4'd0, 4'd0, 4'd0, 1'b0);
      clear = 1'b0;
      cyc(2);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_entry();
      sb_t e;
      tif.enablen = 1'b1;
      key(4'd1);
      push("entry_key1", snap(), 4'd0, 4'd0, 4'd1, 1'b0);
      key(4'd3);
      push("entry_key3", snap(), 4'd0, 4'd1, 4'd3, 1'b0);
      key(4'd0);
      push("entry_key0", snap(), 4'd1, 4'd3, 4'd0, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_borrow();
      sb_t e;
      key(4'd1); key(4'd0); key(4'd0);
      push("borrow_load100", snap(), 4'd1, 4'd0, 4'd0, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      tick();
      push("borrow_100_to_059", tick_first, 4'd0, 4'd5, 4'd9, 1'b0);
      tif.enablen = 1'b1;
      cyc(2);
      key(4'd0); key(4'd1); key(4'd0);
      push("borrow_load010", snap(), 4'd0, 4'd1, 4'd0, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      tick();
      push("borrow_010_to_009", tick_first, 4'd0, 4'd0, 4'd9, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_finish();
      sb_t e;
      tif.enablen = 1'b1;
      cyc(2);
      key(4'd0); key(4'd0); key(4'd2);
      push("finish_load002", snap(), 4'd0, 4'd0, 4'd2, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      tick();
      push("finish_tick1", tick_first, 4'd0, 4'd0, 4'd1, 1'b0);
      tick();
      push("finish_done_pulse", tick_first, 4'd0, 4'd0, 4'd0, 1'b1);
      push("finish_done_drop", tick_after, 4'd0, 4'd0, 4'd0, 1'b0);
      tick();
      push("finish_hold_at_zero", tick_first, 4'd0, 4'd0, 4'd0, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_invalid();
      sb_t e;
      tif.enablen = 1'b1;
      cyc(2);
      key(4'd1); key(4'd2); key(4'd3);
      push("invalid_load123", snap(), 4'd1, 4'd2, 4'd3, 1'b0);
      key(4'hA);
      push("invalid_digit_A", snap(), 4'd1, 4'd2, 4'd3, 1'b0);
      key(4'hF);
      push("invalid_digit_F", snap(), 4'd1, 4'd2, 4'd3, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      key(4'd5);
      push("gated_load_when_cooking", snap(), 4'd1, 4'd2, 4'd3, 1'b0);
      tif.enablen = 1'b1;
      cyc(2);
      tick();
      tick();
      push("gated_tick_in_entry", snap(), 4'd1, 4'd2, 4'd3, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_long_entry();
      sb_t e;
      tif.enablen = 1'b1;
      key(4'd0); key(4'd9); key(4'd9);
      push("long_load099", snap(), 4'd0, 4'd9, 4'd9, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      repeat (9) tick();
      push("long_9_ticks", snap(), 4'd0, 4'd9, 4'd0, 1'b0);
      tick();
      push("long_10th_tick", tick_first, 4'd0, 4'd8, 4'd9, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_count();
      sb_t e;
      tif.enablen = 1'b1;
      cyc(2);
      key(4'd2); key(4'd0); key(4'd0);
      push("midrst_load200", snap(), 4'd2, 4'd0, 4'd0, 1'b0);
      tif.enablen = 1'b0;
      cyc(2);
      repeat (5) tick();
      push("midrst_5_ticks", snap(), 4'd1, 4'd5, 4'd5, 1'b0);
      clear       = 1'b1;
      tif.pgt_1hz = 1'b1;
      cyc(1);
      push("midrst_clear_wins", snap(), 4'd0, 4'd0, 4'd0, 1'b0);
      clear       = 1'b0;
      tif.pgt_1hz = 1'b0;
      cyc(2);
      push("midrst_stays_zero", snap(), 4'd0, 4'd0, 4'd0, 1'b0);
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         total++;
         if (e.obs !== e.exp) $display("FAIL %s: got m/t/o/z/d=%h/%h/%h/%b/%b want %h/%h/%h/%b/%b", e.name,
            e.obs[13:10], e.obs[9:6], e.obs[5:2], e.obs[1], e.obs[0], e.exp[13:10], e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_borrow();
      test_finish();
      test_invalid();
      test_long_entry();
      test_reset_mid_count();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
